// File: rtl/flash_access_arbiter_if.sv
// Request/response bundle between core, debug port, flash read path and the flash access arbiter.
interface flash_access_arbiter_if #(
    parameter int unsigned AW = 12
);
    logic [31:0]   instr_bus_address;
    logic [31:0]   data_bus_addr;
    logic [1:0]    data_bus_mode;
    logic [1:0]    data_bus_reqw;
    logic          dbg_req;
    logic [31:0]   dbg_addr;
    logic [31:0]   flash_rdata;
    logic [AW-1:0] flash_addr;
    logic          stall;
    logic          instr_hold;
    logic          load_valid;
    logic          dbg_ack;
    logic [31:0]   dbg_rdata;
    logic          wr_fault;
    logic          align_fault;

    modport master (
        output instr_bus_address, data_bus_addr, data_bus_mode, data_bus_reqw,
        output dbg_req, dbg_addr, flash_rdata,
        input  flash_addr, stall, instr_hold, load_valid, dbg_ack, dbg_rdata,
        input  wr_fault, align_fault
    );

    modport slave (
        input  instr_bus_address, data_bus_addr, data_bus_mode, data_bus_reqw,
        input  dbg_req, dbg_addr, flash_rdata,
        output flash_addr, stall, instr_hold, load_valid, dbg_ack, dbg_rdata,
        output wr_fault, align_fault
    );
endinterface

// File: rtl/flash_access_arbiter.sv
// Single-port program flash sequencer: arbitrates fetch, CPU loads and debug reads, drives stall/hold.
// Optional misaligned-load trapping is enabled with `define FLASH_ARB_ALIGN_CHECK_EN.
module flash_access_arbiter #(
    parameter logic [31:0] FLASH_LIMIT = 32'h3000,
    parameter int unsigned AW          = 12
) (
    input logic                   clk,
    input logic                   reset,
    flash_access_arbiter_if.slave bus
);
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        LOAD     = 2'd1,
        DBG_ADDR = 2'd2,
        DBG_DATA = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          load_last;
    logic          dbg_ack_q;
    logic [DW-1:0] dbg_rdata_q;
    logic          wr_fault_q;

    logic          flash_load_c;
    logic          flash_write_c;
    logic          misalign_c;
    logic          dbg_pend_c;
    logic          load_go_c;
    logic          stall_c;
    logic          instr_hold_c;
    logic          load_valid_c;
    logic [AW-1:0] flash_addr_c;

    // Data-bus decode of accesses that target the flash region
    assign flash_load_c  = (bus.data_bus_mode == 2'b01) && (bus.data_bus_addr < FLASH_LIMIT);
    assign flash_write_c = (bus.data_bus_mode == 2'b10) && (bus.data_bus_addr < FLASH_LIMIT);
    // The ack cycle masks a still-held dbg_req so one request yields one ack
    assign dbg_pend_c    = bus.dbg_req && !dbg_ack_q;

`ifdef FLASH_ARB_ALIGN_CHECK_EN
    logic align_fault_q;

    assign misalign_c = ((bus.data_bus_reqw == 2'b00) && (bus.data_bus_addr[1:0] != 2'b00)) ||
                        ((bus.data_bus_reqw == 2'b01) && (bus.data_bus_addr[1:0] == 2'b11));

    always_ff @(posedge clk) begin
        if (!reset) begin
            align_fault_q <= 1'b0;
        end else begin
            align_fault_q <= (state == FETCH) && flash_load_c && misalign_c;
        end
    end

    assign bus.align_fault = align_fault_q;
`else
    assign misalign_c      = 1'b0;
    assign bus.align_fault = 1'b0;
`endif

    // A load directly after a load yields to a waiting debug read
    assign load_go_c = (state == FETCH) && flash_load_c && !misalign_c &&
                       !(load_last && dbg_pend_c);

    // Next state and the per-cycle flash address / pipeline control
    always_comb begin
        next_state   = state;
        stall_c      = 1'b0;
        instr_hold_c = 1'b0;
        load_valid_c = 1'b0;
        flash_addr_c = bus.instr_bus_address[AW+1:2];
        if (reset) begin
            unique case (state)
                FETCH: begin
                    if (load_go_c) begin
                        stall_c      = 1'b1;
                        flash_addr_c = bus.data_bus_addr[AW+1:2];
                        next_state   = LOAD;
                    end else if (dbg_pend_c) begin
                        stall_c      = 1'b1;
                        flash_addr_c = bus.dbg_addr[AW+1:2];
                        next_state   = DBG_ADDR;
                    end
                end
                LOAD: begin
                    load_valid_c = 1'b1;
                    instr_hold_c = 1'b1;
                    next_state   = FETCH;
                end
                DBG_ADDR: begin
                    instr_hold_c = 1'b1;
                    next_state   = DBG_DATA;
                end
                DBG_DATA: begin
                    next_state = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= FETCH;
            load_last   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
            wr_fault_q  <= 1'b0;
        end else begin
            state      <= next_state;
            dbg_ack_q  <= (state == DBG_DATA);
            wr_fault_q <= flash_write_c;
            if (state == FETCH) begin
                load_last <= load_go_c;
            end
            if (state == DBG_DATA) begin
                dbg_rdata_q <= bus.flash_rdata;
            end
        end
    end

    assign bus.flash_addr = flash_addr_c;
    assign bus.stall      = stall_c;
    assign bus.instr_hold = instr_hold_c;
    assign bus.load_valid = load_valid_c;
    assign bus.dbg_ack    = dbg_ack_q;
    assign bus.dbg_rdata  = dbg_rdata_q;
    assign bus.wr_fault   = wr_fault_q;

    // Byte-lane and out-of-window address bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{bus.instr_bus_address[DW-1:AW+2], bus.instr_bus_address[1:0],
                           bus.dbg_addr[DW-1:AW+2], bus.dbg_addr[1:0], bus.data_bus_reqw};
endmodule

// File: tb/tb_flash_access_arbiter.sv
// Scoreboard bench for flash_access_arbiter: directed scenarios push expected eventful cycles.
module tb_flash_access_arbiter;
    localparam int unsigned AW = 12;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    flash_access_arbiter_if #(.AW(AW)) bus ();

    flash_access_arbiter #(.FLASH_LIMIT(32'h3000), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash array with a read register that freezes while the fetch path uses its backup copy
    logic [31:0] mem [0:4095];
    logic [31:0] flash_q = 32'h0;
    assign bus.flash_rdata = flash_q;
    always @(posedge clk) if (bus.instr_hold !== 1'b1) flash_q <= mem[bus.flash_addr];

    typedef struct packed {
        int          c;
        logic        stall;
        logic [11:0] addr;
        logic        lv;
        logic        hold;
        logic        ack;
        logic        wf;
        logic        af;
        logic [31:0] rd;
        logic [31:0] dr;
    } exp_t;

    exp_t q[$];

    task automatic push(input int c, input logic st, input logic [11:0] a, input logic lv,
                        input logic hold, input logic ack, input logic wf, input logic af,
                        input logic [31:0] rd, input logic [31:0] dr);
        exp_t e;
        e.c = c; e.stall = st; e.addr = a; e.lv = lv; e.hold = hold; e.ack = ack;
        e.wf = wf; e.af = af; e.rd = lv ? rd : 32'h0; e.dr = ack ? dr : 32'h0;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle with any active status output must match the next expected record
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        while (q.size() > 0 && q[0].c < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_event expected at cyc=%0d (now %0d) stall=%b addr=%h lv=%b hold=%b ack=%b wf=%b af=%b",
                     e.c, cyc, e.stall, e.addr, e.lv, e.hold, e.ack, e.wf, e.af);
        end
        if (bus.stall === 1'b1 || bus.instr_hold === 1'b1 || bus.load_valid === 1'b1 ||
            bus.dbg_ack === 1'b1 || bus.wr_fault === 1'b1 || bus.align_fault === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d stall=%b addr=%h lv=%b hold=%b ack=%b wf=%b af=%b",
                         cyc, bus.stall, bus.flash_addr, bus.load_valid, bus.instr_hold,
                         bus.dbg_ack, bus.wr_fault, bus.align_fault);
            end else begin
                e = q.pop_front();
                a.c = cyc; a.stall = bus.stall; a.addr = bus.flash_addr; a.lv = bus.load_valid;
                a.hold = bus.instr_hold; a.ack = bus.dbg_ack; a.wf = bus.wr_fault;
                a.af = bus.align_fault;
                a.rd = e.lv ? bus.flash_rdata : 32'h0;
                a.dr = e.ack ? bus.dbg_rdata : 32'h0;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard cyc=%0d got stall=%b addr=%h lv=%b hold=%b ack=%b wf=%b af=%b rd=%h dr=%h | expected cyc=%0d stall=%b addr=%h lv=%b hold=%b ack=%b wf=%b af=%b rd=%h dr=%h",
                             a.c, a.stall, a.addr, a.lv, a.hold, a.ack, a.wf, a.af, a.rd, a.dr,
                             e.c, e.stall, e.addr, e.lv, e.hold, e.ack, e.wf, e.af, e.rd, e.dr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // CPU flash load: stall cycle with data address, then load_valid with the word on flash_rdata
    task automatic load_seq(input logic [31:0] a, input logic [1:0] rw, input logic [11:0] wa,
                            input logic [31:0] rd);
        push(cyc, 1'b1, wa, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(cyc + 1, 1'b0, 12'h010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rd, 32'h0);
        bus.data_bus_addr = a;
        bus.data_bus_reqw = rw;
        bus.data_bus_mode = 2'b01;
        step();
        step();
        bus.data_bus_mode = 2'b00;
        idle(2);
    endtask

    // Debug read with dbg_req held through the ack cycle
    task automatic dbg_seq(input logic [31:0] a, input logic [11:0] wa, input logic [31:0] dr);
        push(cyc, 1'b1, wa, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(cyc + 1, 1'b0, 12'h010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(cyc + 3, 1'b0, 12'h010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, dr);
        bus.dbg_addr = a;
        bus.dbg_req  = 1'b1;
        idle(4);
        bus.dbg_req = 1'b0;
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        int c0;
        for (int i = 0; i < 4096; i++) mem[i] = {20'hC0DE0, 12'(i)};
        mem[12'h049] = 32'hDEADBEEF;

        reset                 = 1'b0;
        bus.instr_bus_address = 32'h0000_0040;
        bus.data_bus_addr     = 32'h0000_0010;
        bus.data_bus_mode     = 2'b01;
        bus.data_bus_reqw     = 2'b00;
        bus.dbg_req           = 1'b0;
        bus.dbg_addr          = 32'h0;

        // Reset held with a pending flash load
        repeat (3) begin
            @(negedge clk);
            chk("rst_stall", 32'(bus.stall), 32'h0);
            chk("rst_hold", 32'(bus.instr_hold), 32'h0);
            chk("rst_load_valid", 32'(bus.load_valid), 32'h0);
            chk("rst_dbg_ack", 32'(bus.dbg_ack), 32'h0);
            chk("rst_dbg_rdata", bus.dbg_rdata, 32'h0);
            chk("rst_flash_addr", 32'(bus.flash_addr), 32'h010);
        end

        // Release: the held load at 0x10 is taken immediately
        step();
        reset = 1'b1;
        push(cyc, 1'b1, 12'h004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(cyc + 1, 1'b0, 12'h010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC0DE0004, 32'h0);
        step();
        step();
        bus.data_bus_mode = 2'b00;
        idle(2);

        load_seq(32'h0000_0124, 2'b00, 12'h049, 32'hDEADBEEF);
        dbg_seq(32'h0000_0008, 12'h002, 32'hC0DE0002);

        // Load outside the flash window: no stall
        bus.data_bus_addr = 32'h0000_3000;
        bus.data_bus_mode = 2'b01;
        step();
        bus.data_bus_mode = 2'b00;
        idle(2);

        // Load and debug together; the core re-issues a load that must yield to debug once
        c0 = cyc;
        push(c0, 1'b1, 12'h049, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(c0 + 1, 1'b0, 12'h010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
        push(c0 + 2, 1'b1, 12'h002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(c0 + 3, 1'b0, 12'h010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(c0 + 5, 1'b1, 12'h049, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hC0DE0002);
        push(c0 + 6, 1'b0, 12'h010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
        bus.data_bus_addr = 32'h0000_0124;
        bus.data_bus_reqw = 2'b00;
        bus.data_bus_mode = 2'b01;
        bus.dbg_addr      = 32'h0001_4008;
        bus.dbg_req       = 1'b1;
        idle(6);
        bus.data_bus_mode = 2'b00;
        bus.dbg_req       = 1'b0;
        idle(3);

        // Writes: last flash word faults, first byte past the window does not
        push(cyc + 1, 1'b0, 12'h010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        bus.data_bus_addr = 32'h0000_2FFC;
        bus.data_bus_mode = 2'b10;
        step();
        bus.data_bus_mode = 2'b00;
        idle(2);
        bus.data_bus_addr = 32'h0000_3000;
        bus.data_bus_mode = 2'b10;
        step();
        bus.data_bus_mode = 2'b00;
        idle(2);

        // Misaligned word load at 0x0102
`ifdef FLASH_ARB_ALIGN_CHECK_EN
        push(cyc + 1, 1'b0, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        bus.data_bus_addr = 32'h0000_0102;
        bus.data_bus_reqw = 2'b00;
        bus.data_bus_mode = 2'b01;
        step();
        bus.data_bus_mode = 2'b00;
        idle(2);
`else
        load_seq(32'h0000_0102, 2'b00, 12'h040, 32'hC0DE0040);
`endif
        load_seq(32'h0000_0102, 2'b01, 12'h040, 32'hC0DE0040);
        chk("align_fault_idle", 32'(bus.align_fault), 32'h0);

        // Reset during a debug read: dropped without ack, served again after release
        c0 = cyc;
        push(c0, 1'b1, 12'h002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(c0 + 1, 1'b0, 12'h010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.dbg_addr = 32'h0000_0008;
        bus.dbg_req  = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("rst_mid_dbg_ack", 32'(bus.dbg_ack), 32'h0);
        chk("rst_mid_dbg_rdata", bus.dbg_rdata, 32'h0);
        chk("rst_mid_stall", 32'(bus.stall), 32'h0);
        step();
        reset = 1'b1;
        push(cyc, 1'b1, 12'h002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(cyc + 1, 1'b0, 12'h010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(cyc + 3, 1'b0, 12'h010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hC0DE0002);
        idle(4);
        bus.dbg_req = 1'b0;
        idle(2);

        // Reset during a load: no load_valid for the in-flight access
        push(cyc, 1'b1, 12'h049, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.data_bus_addr = 32'h0000_0124;
        bus.data_bus_reqw = 2'b00;
        bus.data_bus_mode = 2'b01;
        step();
        reset             = 1'b0;
        bus.data_bus_mode = 2'b00;
        @(negedge clk);
        chk("rst_mid_load_addr", 32'(bus.flash_addr), 32'h010);
        chk("rst_mid_load_valid", 32'(bus.load_valid), 32'h0);
        step();
        reset = 1'b1;
        idle(3);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations got=%0d expected=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/flash_access_arbiter.md
# flash_access_arbiter

Sequencer and arbiter for the single-port program flash. Three requesters share the flash: the CPU instruction fetch, CPU data-bus loads from the flash region, and a low-priority debug read port. The block selects the flash word address each cycle and generates the pipeline stall. It also tells the flash read path when the fetched instruction must come from its backup register. It sits between the core/data-bus controller and the flash array with its read/backup registers.

## Interface
Parameters:
- FLASH_LIMIT, 32'h3000, first byte address outside flash; data accesses below it target flash
- AW, 12, flash word-address width (byte address bits [AW+1:2])

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- instr_bus_address  in  32  fetch byte address from core
- data_bus_addr  in  32  data-bus byte address
- data_bus_mode  in  2  00 idle, 01 read, 10 write, 11 reserved (idle)
- data_bus_reqw  in  2  00 word, 01 half, 10 byte
- dbg_req  in  1  debug read request, level
- dbg_addr  in  32  debug byte address, stable while dbg_req high
- flash_rdata  in  32  flash read register (valid the cycle after an address is presented)
- flash_addr  out  AW  word address presented to flash this cycle
- stall  out  1  freezes core pipeline/PC this cycle
- instr_hold  out  1  fetch path must use backup register this cycle
- load_valid  out  1  flash_rdata holds the CPU load word this cycle
- dbg_ack  out  1  one-cycle pulse, dbg_rdata valid
- dbg_rdata  out  32  captured debug word (raw flash order)
- wr_fault  out  1  registered pulse: write attempted to flash region
- align_fault  out  1  registered pulse (only with FLASH_ARB_ALIGN_CHECK_EN)

## Operation
- flash_load = data_bus_mode==01 && data_bus_addr < FLASH_LIMIT (unsigned); flash_write = mode==10 && addr < FLASH_LIMIT.
- States: FETCH, LOAD, DBG_ADDR, DBG_DATA. Reset → FETCH.
- FETCH:
  - flash_load → stall=1 (combinational), flash_addr=data_bus_addr[AW+1:2], next LOAD.
  - Else dbg_req && !dbg_ack → stall=1, flash_addr=dbg_addr[AW+1:2], next DBG_ADDR.
  - Else flash_addr=instr_bus_address[AW+1:2], stall=0.
- LOAD:
  - load_valid=1, instr_hold=1, stall=0, flash_addr=instr address, next FETCH.
  - Data-bus request ignored in this state; the core holds the same load across FETCH→LOAD.
- DBG_ADDR: stall=0, instr_hold=1, flash_addr=instr address, next DBG_DATA.
- DBG_DATA: instr_hold=0, flash_addr=instr address.
  - On exit edge: dbg_rdata<=flash_rdata, dbg_ack<=1.
  - Next FETCH.
  - A CPU load in DBG_ADDR/DBG_DATA waits; it is taken in FETCH.
- Priority in FETCH: CPU load > debug. No starvation: core loads cannot occupy consecutive FETCH cycles.
- dbg_ack is high exactly one cycle (the FETCH after DBG_DATA). A dbg_req still high in that cycle is not a new request; a new request is recognised from the following cycle.
- flash_write in any state → wr_fault=1 next cycle, no stall, no state change.

## Timing
- Reset values: state FETCH, dbg_ack 0, dbg_rdata 0, wr_fault 0, align_fault 0. While reset low: stall 0, instr_hold 0, load_valid 0, flash_addr = instr address.
- CPU flash load: 1 stall cycle. Data is on flash_rdata in the LOAD cycle (address edge +1).
- Debug read: dbg_req seen in FETCH (T0) → stall at T0 only → dbg_ack at T3 with data. Core loses one cycle.
- Reset mid-operation: returns to FETCH. Any pending debug read is dropped without ack (requester keeps dbg_req high; it is served after reset). An in-flight load has no load_valid.
- Address bits above AW+1 are ignored; wrap is modulo flash size.

## Configuration
- FLASH_ARB_ALIGN_CHECK_EN defined:
  - In FETCH, a flash_load is misaligned if word && addr[1:0]!=0, or half && addr[1:0]==11.
  - Misaligned load → no stall, stays FETCH, align_fault=1 next cycle, load_valid never asserted.
- Undefined: align_fault tied 0; misaligned loads sequence as normal loads.

## Test plan
- Reset low 3 cycles with mode=01, addr=0x10 → stall=0, dbg_ack=0, dbg_rdata=0. Release → FETCH stalls with flash_addr=4.
- Load addr=0x0124, flash word 0xDEADBEEF → stall high 1 cycle, flash_addr=0x049; next cycle load_valid=1, instr_hold=1, flash_rdata=0xDEADBEEF.
- dbg_req with dbg_addr=0x0008 while fetching 0x0040 → stall 1 cycle, flash_addr=2, then 0x10 ×2. dbg_ack on 4th cycle, dbg_rdata=flash[2]. dbg_req held → no second ack.
- dbg_req and flash load same cycle → load served first (load_valid), debug stall next FETCH, dbg_ack 4 cycles later.
- Write mode=10 addr=0x2FFC → wr_fault pulse 1 cycle, no stall. Write addr=0x3000 → no fault.
- With FLASH_ARB_ALIGN_CHECK_EN: word load addr=0x0102 → align_fault pulse, no stall. Half load addr=0x0102 → normal load. Without macro: word load addr=0x0102 → normal load, align_fault=0.
